// File: rtl/button_direction_encoder.sv
// Direction-button front end for the snake game.
// Synchronises and debounces the four direction buttons, converts each
// debounced press into a 2-bit heading command, rejects same-heading and
// reversing turns, and buffers accepted commands in a 2-entry queue that
// the position controller drains with a valid/ready handshake.
module button_direction_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [1:0] dir_code,
  output logic [1:0] current_dir,
  output logic [7:0] drop_count,
  output logic [1:0] queue_level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       DIR_RIGHT = 2'b11;

  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [3:0]       prevStable_q;
  logic [3:0]       press_q;

  logic             evtValid;
  logic [1:0]       evtCode;
  logic [2:0]       pressCount;
  logic [2:0]       multiDrops;

  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [1:0]       level_q, level_d;
  logic             valid_q, valid_d;
  logic [1:0]       cur_q, cur_d;
  logic [7:0]       drop_q, drop_d;

  logic [1:0]       lastQueued;
  logic [1:0]       refDir;
  logic             legal;
  logic             pop;
  logic             push;
  logic             overflow;
  logic [8:0]       dropSum;

  // Two-flop synchroniser bringing the asynchronous button pins into the clock domain.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a button's stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state plus the registered one-cycle rising-edge press pulse.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
      end
      stable_q     <= '0;
      prevStable_q <= '0;
      press_q      <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      stable_q     <= stable_d;
      prevStable_q <= stable_q;
      press_q      <= stable_q & ~prevStable_q;
    end
  end

  // Pick the lowest-index press when several land together; the rest are counted as drops.
  always_comb begin
    evtValid   = |press_q;
    evtCode    = 2'b00;
    pressCount = 3'(press_q[0]) + 3'(press_q[1]) + 3'(press_q[2]) + 3'(press_q[3]);
    multiDrops = 3'd0;
    if (press_q[0]) begin
      evtCode = 2'b00;
    end else if (press_q[1]) begin
      evtCode = 2'b01;
    end else if (press_q[2]) begin
      evtCode = 2'b10;
    end else if (press_q[3]) begin
      evtCode = 2'b11;
    end
    if (evtValid) begin
      multiDrops = pressCount - 3'd1;
    end
  end

  // Turn filter against the newest queued heading, queue update, pop handling and drop counting.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    level_d    = level_q;
    cur_d      = cur_q;
    lastQueued = (level_q == 2'd2) ? tail_q : head_q;
    refDir     = (level_q != 2'd0) ? lastQueued : cur_q;
    legal      = evtValid && (evtCode[1] != refDir[1]);
    pop        = valid_q && dir_ready;
    push       = legal && ((level_q != 2'd2) || pop);
    overflow   = legal && !push;

    if (pop) begin
      cur_d = head_q;
    end

    unique case ({push, pop})
      2'b10: begin
        if (level_q == 2'd0) begin
          head_d = evtCode;
        end else begin
          tail_d = evtCode;
        end
        level_d = level_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        level_d = level_q - 2'd1;
      end
      2'b11: begin
        if (level_q == 2'd1) begin
          head_d = evtCode;
        end else begin
          head_d = tail_q;
          tail_d = evtCode;
        end
      end
      default: begin
      end
    endcase

    valid_d = (level_d != 2'd0);
    dropSum = {1'b0, drop_q} + 9'(multiDrops) + 9'(overflow);
    drop_d  = (dropSum > 9'd255) ? 8'hFF : dropSum[7:0];
  end

  // Queue, heading and drop-counter registers; reset leaves the snake heading right.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      head_q  <= 2'b00;
      tail_q  <= 2'b00;
      level_q <= 2'd0;
      valid_q <= 1'b0;
      cur_q   <= DIR_RIGHT;
      drop_q  <= 8'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      level_q <= level_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      drop_q  <= drop_d;
    end
  end

  assign dir_valid   = valid_q;
  assign dir_code    = head_q;
  assign current_dir = cur_q;
  assign drop_count  = drop_q;
  assign queue_level = level_q;

endmodule
